// File: rtl/array_mul_pkg.sv
// rtl/array_mul_pkg.sv - shared constants and partial-product helper for array_mul_pipe
package array_mul_pkg;

    localparam int   DEFAULT_WIDTH  = 8;
    localparam int   DEFAULT_STAGES = 2;
    localparam logic MODE_UNSIGNED  = 1'b0;
    localparam logic MODE_SIGNED    = 1'b1;

    // Baugh-Wooley: in signed mode a product pairing exactly one sign bit is complemented.
    function automatic logic pp_bit(input logic aj, input logic bi, input logic mode,
                                    input logic one_sign);
        return (aj & bi) ^ ((mode == MODE_SIGNED) & one_sign);
    endfunction

endpackage

// File: rtl/array_mul_pipe_row.sv
// rtl/array_mul_pipe_row.sv - one reduction row: adds partial-product row ROW into the accumulator
module array_mul_pipe_row
    import array_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ROW   = 0
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   a,
    input  logic               b,
    input  logic               tc,
    output logic [2*WIDTH-1:0] acc_out
);

    localparam int PW = 2 * WIDTH;

    for (genvar c = 0; c < PW; c++) begin : g_col
        logic pp;
        logic cin;

        if (c >= ROW && c < ROW + WIDTH) begin : g_pp
            assign pp = pp_bit(a[c-ROW], b, tc,
                               1'((ROW == WIDTH - 1) != (c - ROW == WIDTH - 1)));
        end else begin : g_zero
            assign pp = 1'b0;
        end

        if (c == 0) begin : g_cin0
            assign cin = 1'b0;
        end else begin : g_cin
            assign cin = g_col[c-1].g_fa.cout;
        end

        // The carry out of the top column falls outside the 2*WIDTH result and is dropped.
        if (c < PW - 1) begin : g_fa
            logic cout;
            full_adder u_fa (
                .a   (acc_in[c]),
                .b   (pp),
                .cin (cin),
                .sum (acc_out[c]),
                .cout(cout)
            );
        end else begin : g_top
            assign acc_out[c] = acc_in[c] ^ pp ^ cin;
        end
    end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell used by the multiplier array
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array_mul_pipe.sv
// rtl/array_mul_pipe.sv - pipelined unsigned/Baugh-Wooley array multiplier with valid/ready handshake
module array_mul_pipe
    import array_mul_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);

    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = (WIDTH + STAGES - 1) / STAGES;

    logic             v_q   [STAGES];
    logic             tc_q  [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [PW-1:0]    acc_q [STAGES];
    logic [PW-1:0]    acc_d [STAGES];
    logic             adv;

    // Signed mode starts the accumulator at 2^WIDTH + 2^(2*WIDTH-1) to fold in the sign terms.
    function automatic logic [PW-1:0] bw_seed(input logic mode);
        logic [PW-1:0] k;
        k        = '0;
        k[PW-1]  = (mode == MODE_SIGNED);
        k[WIDTH] = (mode == MODE_SIGNED);
        return k;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [PW-1:0] seed;

        if (s == 0) begin : g_seed_in
            assign seed = bw_seed(tc);
        end else begin : g_seed_reg
            assign seed = acc_q[s-1];
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int ROW = s * ROWS + r;
            logic [PW-1:0] acc_in;
            logic [PW-1:0] acc_out;

            if (r == 0) begin : g_first
                assign acc_in = seed;
            end else begin : g_chain
                assign acc_in = g_row[r-1].acc_out;
            end

            if (ROW < WIDTH) begin : g_add
                logic [WIDTH-1:0] row_a;
                logic             row_b;
                logic             row_tc;

                if (s == 0) begin : g_src_in
                    assign row_a  = a;
                    assign row_b  = b[ROW];
                    assign row_tc = tc;
                end else begin : g_src_reg
                    assign row_a  = a_q[s-1];
                    assign row_b  = b_q[s-1][ROW];
                    assign row_tc = tc_q[s-1];
                end

                array_mul_pipe_row #(
                    .WIDTH(WIDTH),
                    .ROW  (ROW)
                ) u_row (
                    .acc_in (acc_in),
                    .a      (row_a),
                    .b      (row_b),
                    .tc     (row_tc),
                    .acc_out(acc_out)
                );
            end else begin : g_pass
                assign acc_out = acc_in;
            end
        end

        assign acc_d[s] = g_row[ROWS-1].acc_out;
    end

    assign adv       = !out_valid || out_ready;
    assign in_ready  = rst || adv;
    assign out_valid = v_q[STAGES-1];
    assign prod      = acc_q[STAGES-1];

    // Data registers load only behind a valid bit so prod keeps the last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]   <= 1'b0;
                tc_q[s]  <= MODE_UNSIGNED;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                acc_q[s] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                tc_q[0]  <= tc;
                a_q[0]   <= a;
                b_q[0]   <= b;
                acc_q[0] <= acc_d[0];
            end
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
                if (v_q[s-1]) begin
                    tc_q[s]  <= tc_q[s-1];
                    a_q[s]   <= a_q[s-1];
                    b_q[s]   <= b_q[s-1];
                    acc_q[s] <= acc_d[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_array_mul_pipe.sv
// tb/tb_array_mul_pipe.sv - scoreboard bench for array_mul_pipe, directed cases plus parameter sweep
module tb_array_mul_pipe;

    localparam int STG  = 2;
    localparam int NCFG = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        tc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] prod;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          sw_done = 0;
    logic        last_acc = 1'b0;
    logic [63:0] cur_exp = '0;
    logic [63:0] expq [$];
    int          in_cyc [$];
    int          out_cyc [$];

    always #5 clk = ~clk;

    array_mul_pipe #(.WIDTH(8), .STAGES(STG)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .tc       (tc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod     (prod)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic t, input int w);
        longint      sx;
        longint      sy;
        logic [63:0] m;
        m  = (64'd1 << (2 * w)) - 64'd1;
        sx = longint'(x);
        sy = longint'(y);
        if (t && x[w-1]) sx = sx - (longint'(1) << w);
        if (t && y[w-1]) sy = sy - (longint'(1) << w);
        return 64'(sx * sy) & m;
    endfunction

    function automatic int cfg_w(input int k);
        case (k)
            0, 1:    return 3;
            2, 3, 4: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_s(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 1;
            3:       return 3;
            4:       return 8;
            5:       return 1;
            6:       return 3;
            default: return 16;
        endcase
    endfunction

    // Inputs are set at the falling edge; handshakes are evaluated just before the next rising edge.
    task automatic tick();
        #1;
        last_acc = 1'b0;
        if (!rst) begin
            if (in_valid && in_ready) begin
                expq.push_back(cur_exp);
                in_cyc.push_back(cyc);
                last_acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (expq.size() == 0) check_eq("spurious_out", 64'(out_valid), 64'd0);
                else check_eq("prod", 64'(prod), expq.pop_front());
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic t,
                        input logic [63:0] e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        tc       = t;
        cur_exp  = e;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            tick();
            n++;
        end
        if (!last_acc) check_eq("send_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (expq.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic measure_latency(input string tag);
        int edges;
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check_eq(tag, 64'(edges), 64'(STG));
    endtask

    initial begin
        int n0;
        logic [63:0] held;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_prod", 64'(prod), 64'd0);
        rst    = 1'b0;
        sw_rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        out_ready = 1'b1;
        send(8'hFF, 8'hFF, 1'b0, 64'hFE01);
        measure_latency("latency_ff");
        check_eq("prod_ff", 64'(prod), 64'hFE01);
        drain();

        send(8'h80, 8'h80, 1'b1, 64'h4000);
        send(8'hFF, 8'h01, 1'b1, 64'hFFFF);
        send(8'h7F, 8'h80, 1'b1, 64'hC080);
        drain();

        in_cyc.delete();
        out_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            logic       t;
            x = 8'($urandom);
            y = 8'($urandom);
            t = 1'(i % 2);
            send(x, y, t, ref_mul(32'(x), 32'(y), t, 8));
        end
        drain();
        check_eq("b2b_n_out", 64'(out_cyc.size()), 64'd16);
        if (out_cyc.size() == 16 && in_cyc.size() == 16) begin
            check_eq("b2b_out_span", 64'(out_cyc[15] - out_cyc[0]), 64'd15);
            check_eq("b2b_in_span", 64'(in_cyc[15] - in_cyc[0]), 64'd15);
        end

        out_ready = 1'b0;
        n0 = out_cyc.size();
        send(8'd13, 8'd11, 1'b0, 64'd143);
        send(8'hF0, 8'h03, 1'b1, 64'hFFD0);
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd100;
        tc       = 1'b0;
        cur_exp  = 64'd20000;
        held     = (expq.size() > 0) ? expq[0] : 64'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_prod_stable", 64'(prod), held);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        in_valid = 1'b0;
        drain();
        check_eq("bp_n_out", 64'(out_cyc.size() - n0), 64'd3);

        send(8'd7, 8'd9, 1'b0, 64'd63);
        send(8'd5, 8'd6, 1'b0, 64'd30);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 8'd3;
        b         = 8'd3;
        out_ready = 1'b0;
        #1;
        check_eq("rst_busy_in_ready", 64'(in_ready), 64'd1);
        tick();
        expq.delete();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("midrst_prod", 64'(prod), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        send(8'd12, 8'd12, 1'b0, 64'd144);
        measure_latency("latency_after_rst");
        drain();

        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom);
            a         = 8'($urandom);
            b         = 8'($urandom);
            tc        = 1'($urandom);
            cur_exp   = ref_mul(32'(a), 32'(b), tc, 8);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        for (int i = 0; i < 2000 && sw_done < NCFG; i++) @(negedge clk);
        check_eq("sweep_done", 64'(sw_done), 64'(NCFG));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    for (genvar k = 0; k < NCFG; k++) begin : g_sweep
        localparam int W = cfg_w(k);
        localparam int S = cfg_s(k);

        logic           iv = 1'b0;
        logic           ir;
        logic           ov;
        logic           orr = 1'b0;
        logic           t = 1'b0;
        logic [W-1:0]   x = '0;
        logic [W-1:0]   y = '0;
        logic [2*W-1:0] p;
        logic [63:0]    q [$];

        array_mul_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst      (sw_rst),
            .in_valid (iv),
            .in_ready (ir),
            .a        (x),
            .b        (y),
            .tc       (t),
            .out_valid(ov),
            .out_ready(orr),
            .prod     (p)
        );

        initial begin
            wait (!sw_rst);
            @(negedge clk);
            for (int n = 0; n < 400; n++) begin
                iv = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 5))
                    0:       x = '1;
                    1:       x = W'(1) << (W - 1);
                    default: x = W'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       y = '1;
                    1:       y = W'(1) << (W - 1);
                    default: y = W'($urandom);
                endcase
                t   = 1'($urandom);
                orr = ($urandom_range(0, 2) != 0);
                if (n >= 360) begin
                    iv  = 1'b0;
                    orr = 1'b1;
                end
                #1;
                if (iv && ir) q.push_back(ref_mul(32'(x), 32'(y), t, W));
                if (ov && orr) begin
                    if (q.size() == 0) check_eq("sweep_spurious", 64'(ov), 64'd0);
                    else check_eq($sformatf("sweep_w%0d_s%0d", W, S), 64'(p), q.pop_front());
                end
                @(negedge clk);
            end
            check_eq($sformatf("sweep_left_w%0d_s%0d", W, S), 64'(q.size()), 64'd0);
            sw_done++;
        end
    end

endmodule

// File: doc/array_mul_pipe.md
ARRAY_MUL_PIPE -- requirements
Module: array_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter STAGES, default 2, count of register stages in the product datapath; legal range 1..WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, tc are presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port tc  input  1  mode: 0 = unsigned, 1 = two's-complement; sampled with the operands.
REQ-010 SHALL have port out_valid  output  1  prod holds a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts prod this cycle.
REQ-012 SHALL have port prod  output  2*WIDTH  product, unsigned or two's-complement per the sampled tc.

Function
REQ-013 SHALL accept an input transfer on any rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL deliver an output transfer on any rising edge where out_valid and out_ready are both 1.
REQ-015 SHALL compute prod = a*b exactly, with no truncation, in 2*WIDTH bits.
REQ-016 SHALL use unsigned interpretation when tc=0 and Baugh-Wooley signed interpretation when tc=1.
REQ-017 SHALL form the product as an array of AND partial products reduced by rows of full adders.
REQ-018 SHALL split the WIDTH reduction rows into STAGES groups of ceil(WIDTH/STAGES) rows, with a register after each group; the last group may be short.
REQ-019 SHALL assert out_valid exactly STAGES cycles after the accepting edge when the pipeline is not stalled.
REQ-020 SHALL sustain one accepted operand pair per cycle while out_ready=1.
REQ-021 SHALL keep a per-stage valid bit and carry each operation's tc with its data.
REQ-022 SHALL stall globally: in_ready = !out_valid | out_ready, and every stage register holds its value while in_ready=0.
REQ-023 SHALL let empty stages (valid=0) advance during a stall only if the implementation also proves ordering is preserved; otherwise the global stall of REQ-022 applies.
REQ-024 SHALL hold prod and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL accept a new pair on the same edge that the final result leaves, with no bubble.
REQ-026 SHALL keep prod at its last value when out_valid=0; consumers ignore prod in that state.
REQ-027 SHALL produce, for WIDTH=2, STAGES=1, tc=0, a result identical to the combinational array product registered once.

Reset
REQ-028 SHALL, on a rising edge with rst=1, clear every stage valid bit, out_valid and prod to 0.
REQ-029 SHALL drive in_ready=1 during reset and on the first cycle after reset.
REQ-030 SHALL discard all in-flight operations on a mid-operation reset; no result from before reset ever appears at prod.
REQ-031 SHALL give rst priority over a simultaneous input or output transfer; the transfer does not occur.

Structure
REQ-032 SHALL place the default WIDTH, the default STAGES and the named mode constants (MODE_UNSIGNED=0, MODE_SIGNED=1) in shared package array_mul_pkg.
REQ-033 SHALL build the reduction from instances of the existing sub-module full_adder (ports a, b, cin, sum, cout), generated per row and column.
REQ-034 SHALL stay within about 120-400 lines of RTL, with no vendor multiplier primitives.

Verification
REQ-035 SHALL check WIDTH=8, STAGES=2, tc=0, a=255, b=255 -> prod=0xFE01, with out_valid 2 cycles after accept.
REQ-036 SHALL check tc=1: a=0x80, b=0x80 -> 0x4000; a=0xFF, b=0x01 -> 0xFFFF; a=0x7F, b=0x80 -> 0xC080.
REQ-037 SHALL check 16 back-to-back pairs with out_ready=1 -> 16 correct results on 16 consecutive cycles, in order.
REQ-038 SHALL check backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, prod stable, no loss or duplication after release.
REQ-039 SHALL check reset: assert rst for 1 cycle with 2 operations in flight -> out_valid stays 0 until a new accepted pair has passed through STAGES cycles.
REQ-040 SHALL run a random sweep over WIDTH in {3, 8, 16} and STAGES in {1, 3, WIDTH} with mixed tc and random out_ready -> every prod matches a reference model.
